// File: rtl/ula_inv.sv
// Unsigned subtract / restoring divide unit with a start/busy/done handshake.
// Optional build macro ULA_INV_BORROW_EN: flag a borrow on erro for subtraction.
module ula_inv #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] e0,
    input  logic [DATA_W-1:0] e1,
    input  logic              h,
    input  logic              start,
    output logic [DATA_W-1:0] s,
    output logic [DATA_W-1:0] r,
    output logic              busy,
    output logic              done,
    output logic              erro
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_d;
    logic [DATA_W-1:0] rem_w;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_nxt;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it does not go negative.
    // The extra trial bit covers a partial remainder of up to 2*divisor-1.
    function automatic logic [2*DATA_W-1:0] div_step(
        input logic [DATA_W-1:0] rem,
        input logic [DATA_W-1:0] quo,
        input logic [DATA_W-1:0] dvs
    );
        logic [DATA_W:0] trial;
        trial = {rem, quo[DATA_W-1]};
        if (trial >= {1'b0, dvs}) begin
            trial = trial - {1'b0, dvs};
            return {trial[DATA_W-1:0], quo[DATA_W-2:0], 1'b1};
        end
        return {trial[DATA_W-1:0], quo[DATA_W-2:0], 1'b0};
    endfunction

    assign {rem_nxt, quo_nxt} = div_step(rem_w, op_a, op_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (h && (e1 != '0)) ? CALC : DONE;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == LAST_STEP) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // h itself is not kept: a division in progress is recorded by the CALC state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            op_a  <= '0;
            op_d  <= '0;
            rem_w <= '0;
            s     <= '0;
            r     <= '0;
            erro  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= e0;
                        op_d  <= e1;
                        rem_w <= '0;
                        cnt   <= '0;
                        if (!h) begin
                            s <= e0 - e1;
                            r <= '0;
`ifdef ULA_INV_BORROW_EN
                            erro <= (e0 < e1);
`else
                            erro <= 1'b0;
`endif
                        end else if (e1 == '0) begin
                            s    <= '1;
                            r    <= e0;
                            erro <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    op_a  <= quo_nxt;
                    rem_w <= rem_nxt;
                    cnt   <= cnt + 1'b1;
                    // s/r only see the finished quotient and remainder
                    if (cnt == LAST_STEP) begin
                        s    <= quo_nxt;
                        r    <= rem_nxt;
                        erro <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
